// File: rtl/ecg_pkg.sv
// Shared ECG datapath constants and the ADC code conversion helper.
//   ECG_INOUT_WIDTH : sample width on the filter-chain AXIS buses
//   ECG_FS_HZ       : ECG sample rate
//   ECG_CLK_HZ      : system clock rate
//   ECG_CLK_DIV     : system clock cycles per sample period
//   offset_to_signed: offset-binary ADC code -> left-justified two's complement
package ecg_pkg;

  localparam int unsigned ECG_INOUT_WIDTH = 16;
  localparam int unsigned ECG_FS_HZ       = 500;
  localparam int unsigned ECG_CLK_HZ      = 100_000_000;
  localparam int unsigned ECG_CLK_DIV     = ECG_CLK_HZ / ECG_FS_HZ;

  // code holds the ADC value right-justified. Any bits at or above adc_w are shifted
  // out by the final left shift, so the caller does not need to mask them.
  function automatic logic [ECG_INOUT_WIDTH-1:0] offset_to_signed(
    input logic [ECG_INOUT_WIDTH-1:0] code,
    input int unsigned                adc_w
  );
    logic [ECG_INOUT_WIDTH-1:0] flipped;
    flipped = code ^ (ECG_INOUT_WIDTH'(1) << (adc_w - 1));
    return flipped << (ECG_INOUT_WIDTH - adc_w);
  endfunction

endpackage

// File: rtl/ecg_axis_sample_source_if.sv
// AXI4-Stream data channel (tdata/tvalid/tready) between the sample source and
// the filter input.
//   master: drives tdata, tvalid; receives tready
//   slave : receives tdata, tvalid; drives tready
interface ecg_axis_sample_source_if
  import ecg_pkg::*;
#(
  parameter int unsigned width = ECG_INOUT_WIDTH
) ();

  logic [width-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock circular-buffer FIFO with first-word-fall-through read data.
//   clk_i, rst_i : clock, synchronous active-high reset (clears pointers)
//   wr_en_i      : write wr_data_i (ignored when full)
//   rd_en_i      : pop the head (ignored when empty)
//   rd_data_o    : current head entry, valid while empty_o = 0
//   full_o       : no free entries
//   empty_o      : no stored entries
//   level_o      : number of stored entries, 0..depth
module axis_sync_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [width-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(depth):0] level_o
);

  localparam int unsigned AddrW = $clog2(depth);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [width-1:0] mem_q [depth];
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; contents are only visible through the pointers.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ecg_axis_sample_source.sv
// ECG sample source: paces the ADC, converts its offset-binary codes to signed
// samples, buffers them and presents them as an AXI4-Stream master.
//   clk, rst       : clock, synchronous active-high reset
//   enable         : run control; 0 stops convst ticks and ignores adc_valid
//   adc_convst     : one-cycle conversion-start pulse per sample period
//   adc_valid      : adc_data strobe
//   adc_data       : offset-binary ADC code
//   m_axis         : AXIS master (tdata = signed sample)
//   fifo_level     : FIFO occupancy, not counting the output register
//   overflow       : sticky, a sample was dropped on a full FIFO
//   overflow_clr   : clears overflow and overflow_count
//   overflow_count : dropped-sample count, saturating
module ecg_axis_sample_source
  import ecg_pkg::*;
#(
  parameter int unsigned adc_width   = 12,
  parameter int unsigned inout_width = ECG_INOUT_WIDTH,
  parameter int unsigned clk_div     = ECG_CLK_DIV,
  parameter int unsigned fifo_depth  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        adc_convst,
  input  logic                        adc_valid,
  input  logic [adc_width-1:0]        adc_data,
  ecg_axis_sample_source_if.master    m_axis,
  output logic [$clog2(fifo_depth):0] fifo_level,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic [15:0]                 overflow_count
);

  localparam int unsigned CntW = $clog2(clk_div);
  localparam logic [CntW-1:0] CntLast = CntW'(clk_div - 1);

  // ---------------------------------------------------------------------------
  // Sample-period tick
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable)               cnt_d = '0;
    else if (cnt_q == CntLast) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q is held at 0 by reset and by enable=0, so the pulse cannot fire then.
  assign adc_convst = enable && (cnt_q == CntLast);

  // ---------------------------------------------------------------------------
  // Conversion and FIFO write / drop
  // ---------------------------------------------------------------------------
  logic [inout_width-1:0] conv_data;
  logic                   fifo_full, fifo_empty;
  logic [inout_width-1:0] fifo_head;
  logic                   sample_in, fifo_wr, drop;
  logic                   load;

  assign conv_data = inout_width'(offset_to_signed(ECG_INOUT_WIDTH'(adc_data), adc_width));

  assign sample_in = adc_valid && enable;
  // A pop in the same cycle does not make room: a full FIFO always drops.
  assign fifo_wr   = sample_in && !fifo_full;
  assign drop      = sample_in && fifo_full;

  axis_sync_fifo #(
    .width (inout_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (conv_data),
    .rd_en_i   (load),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Overflow tracking
  // ---------------------------------------------------------------------------
  logic        overflow_q, overflow_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (overflow_clr) begin
      // A drop coinciding with the clear is the first of a new count.
      overflow_d = drop;
      ovf_cnt_d  = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign overflow       = overflow_q;
  assign overflow_count = ovf_cnt_q;

  // ---------------------------------------------------------------------------
  // AXIS output register
  // ---------------------------------------------------------------------------
  logic                   out_valid_q, out_valid_d;
  logic [inout_width-1:0] out_data_q, out_data_d;

  // Refill whenever the register is empty or its beat is leaving this edge.
  assign load = !fifo_empty && (!out_valid_q || m_axis.tready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_head;
    end else if (m_axis.tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;

endmodule

// File: tb/tb_ecg_axis_sample_source.sv
// Self-checking bench for ecg_axis_sample_source (clk_div=10, fifo_depth=16).
module tb_ecg_axis_sample_source;

  localparam int unsigned Depth = 16;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        adc_convst;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] overflow_count;

  ecg_axis_sample_source_if #(.width(16)) axis ();

  ecg_axis_sample_source #(
    .adc_width   (12),
    .inout_width (16),
    .clk_div     (10),
    .fifo_depth  (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .adc_convst     (adc_convst),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .m_axis         (axis),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
    .overflow_count (overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of converted samples, oldest first (output register entry at the front).
  logic [15:0] sb[$];

  // Reference model of occupancy and overflow state.
  int          m_fifo;
  bit          m_valid;
  bit          m_ovf;
  int          m_cnt;
  int          n_push, n_acc, n_drop;

  function automatic logic [15:0] conv(input logic [11:0] d);
    return {~d[11], d[10:0], 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_fifo  = 0;
    m_valid = 0;
    m_ovf   = 0;
    m_cnt   = 0;
    sb.delete();
  endtask

  // Hold rst for n edges; all outputs must read zero after each.
  task automatic reset_dut(input int n);
    rst          = 1'b1;
    adc_valid    = 1'b0;
    overflow_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_tvalid", 32'(axis.tvalid), 0);
      chk("rst_tdata", 32'(axis.tdata), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_ovf_cnt", 32'(overflow_count), 0);
      chk("rst_convst", 32'(adc_convst), 0);
    end
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, score the beat leaving at this edge, advance
  // the model, then check outputs after the edge.
  task automatic drive(input logic push, input logic [11:0] data, input logic ready,
                       input logic clr);
    logic        wr, drop, load, stall;
    logic [15:0] held, exp_d;
    adc_valid    = push;
    adc_data     = data;
    axis.tready  = ready;
    overflow_clr = clr;
    stall = m_valid && !ready;
    held  = axis.tdata;
    if (m_valid && ready) begin
      n_acc++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_d = sb.pop_front();
        chk("tdata", 32'(axis.tdata), 32'(exp_d));
      end
    end
    wr   = push && enable && (m_fifo < Depth);
    drop = push && enable && (m_fifo == Depth);
    if (push && enable) n_push++;
    if (wr) sb.push_back(conv(data));
    if (drop) n_drop++;
    load    = (m_fifo > 0) && (!m_valid || ready);
    m_fifo  = m_fifo + (wr ? 1 : 0) - (load ? 1 : 0);
    m_valid = load || (m_valid && !ready);
    if (clr) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    @(posedge clk); #1;
    adc_valid    = 1'b0;
    overflow_clr = 1'b0;
    chk("tvalid", 32'(axis.tvalid), 32'(m_valid));
    chk("fifo_level", 32'(fifo_level), 32'(m_fifo));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("overflow_count", 32'(overflow_count), 32'(m_cnt));
    if (stall) chk("stall_stable", 32'(axis.tdata), 32'(held));
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    adc_valid    = 1'b0;
    adc_data     = '0;
    overflow_clr = 1'b0;
    axis.tready  = 1'b0;
    n_push = 0; n_acc = 0; n_drop = 0;
    model_clear();

    // Reset, then enable while still in reset: no ticks.
    reset_dut(2);
    enable = 1'b1;
    reset_dut(3);

    // Tick counter: pulse in every 10th cycle after enable, counter at 9.
    for (int i = 1; i <= 30; i++) begin
      drive(1'b0, 12'h000, 1'b1, 1'b0);
      chk("convst", 32'(adc_convst), (i % 10 == 9) ? 1 : 0);
    end
    enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 12'h000, 1'b1, 1'b0);
      chk("convst_disabled", 32'(adc_convst), 0);
    end
    // Samples are ignored while disabled.
    drive(1'b1, 12'hABC, 1'b1, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0);

    // Conversion examples with tready=1.
    enable = 1'b1;
    drive(1'b1, 12'h800, 1'b1, 1'b0);
    drive(1'b1, 12'hFFF, 1'b1, 1'b0);
    drive(1'b1, 12'h000, 1'b1, 1'b0);
    drive(1'b1, 12'h801, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);
    chk("conv_sb_empty", 32'(sb.size()), 0);

    // Fill under back-pressure: 17 fit, the 18th drops.
    reset_dut(1);
    for (int i = 0; i < 17; i++) drive(1'b1, 12'(i * 37 + 5), 1'b0, 1'b0);
    chk("full_level", 32'(fifo_level), 16);
    chk("full_tvalid", 32'(axis.tvalid), 1);
    chk("full_head", 32'(axis.tdata), 32'(conv(12'd5)));
    drive(1'b1, 12'h123, 1'b0, 1'b0);
    chk("drop_count", 32'(overflow_count), 1);
    for (int i = 0; i < 20; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);
    chk("drain_sb_empty", 32'(sb.size()), 0);

    // Clear coinciding with a drop, then clear alone.
    for (int i = 0; i < 17; i++) drive(1'b1, 12'(4095 - i * 11), 1'b0, 1'b0);
    drive(1'b1, 12'h456, 1'b0, 1'b0);
    drive(1'b1, 12'h789, 1'b0, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);

    // Random back-pressure with a sample every cycle.
    reset_dut(1);
    n_push = 0; n_acc = 0; n_drop = 0;
    for (int i = 0; i < 1000; i++)
      drive(1'b1, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);
    chk("rand_sb_empty", 32'(sb.size()), 0);
    chk("rand_conservation", 32'(n_acc + n_drop), 32'(n_push));

    // Reset with data buffered and a pending beat.
    for (int i = 0; i < 6; i++) drive(1'b1, 12'(i * 100 + 7), 1'b0, 1'b0);
    chk("prerst_level", 32'(fifo_level), 5);
    reset_dut(1);
    drive(1'b1, 12'h3C5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 12'h000, 1'b1, 1'b0);
    chk("postrst_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecg_axis_sample_source.md
Name: ecg_axis_sample_source

Overview:
- AXI4-Stream transmitter that feeds ECG samples into the bandpass filter chain's s_axis input.
- Paces the ADC with a conversion-start tick at fs and converts offset-binary ADC codes to signed two's-complement samples.
- Buffers samples in a small FIFO so that filter back-pressure never silently drops data. Overflow is counted and flagged.
- Sits between the ADC capture logic and the filter input.

Parameters:
- adc_width, 12, ADC code width in bits, offset binary; must be <= inout_width
- inout_width, 16, AXIS tdata width; matches the filter inout_width
- clk_div, 200000, clk cycles per sample period (100 MHz / 500 Hz); must be >= 2
- fifo_depth, 16, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run control; 0 stops conversion ticks and ignores adc_valid
- adc_convst  out  1  one-cycle conversion-start pulse, one per sample period
- adc_valid  in  1  one-cycle strobe; adc_data is valid in this cycle
- adc_data  in  adc_width  offset-binary ADC code
- m_axis_tdata  out  inout_width  signed sample
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready from the filter
- fifo_level  out  $clog2(fifo_depth)+1  FIFO occupancy, excluding the output register
- overflow  out  1  sticky flag: a sample was dropped
- overflow_clr  in  1  clears overflow and overflow_count
- overflow_count  out  16  dropped-sample count, saturates at 16'hFFFF

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high on rst. Everything is sampled on the rising edge of clk.
  - On reset, all outputs go to 0: adc_convst, m_axis_tvalid, m_axis_tdata, fifo_level, overflow, overflow_count. Tick counter and FIFO pointers also clear to 0.
  - Reset mid-transfer discards all buffered samples and any pending beat.
- Tick counter:
  - Counts 0..clk_div-1 while enable=1 and wraps to 0.
  - adc_convst=1 for exactly one cycle when the counter equals clk_div-1.
  - enable=0 holds the counter at 0 and forces adc_convst=0.
  - After enable rises, the first pulse occurs clk_div cycles later.
- Conversion (combinational, before FIFO write):
  - Invert the MSB of adc_data, then left-shift by (inout_width - adc_width).
  - Examples: 12'h800 -> 16'h0000; 12'hFFF -> 16'h7FF0; 12'h000 -> 16'h8000; 12'h801 -> 16'h0010.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr one bit wider than the address.
  - Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal. Pointers wrap naturally.
  - A write occurs when adc_valid=1, enable=1 and the FIFO is not full.
  - If adc_valid=1, enable=1 and the FIFO is full, the sample is dropped: overflow <= 1 and overflow_count increments with saturation.
  - A simultaneous read in the same cycle does not free space for that write; a full FIFO still drops.
  - overflow_clr=1 clears overflow and overflow_count. If a drop occurs in the same cycle, the result is overflow=1 and count=1.
- Output register (AXIS master):
  - Loads from the FIFO head when the FIFO is non-empty and the register is empty or being consumed (m_axis_tvalid=0 or m_axis_tready=1). A load pops the FIFO.
  - Simultaneous write and pop is allowed at any level except full-drop.
  - Latency: adc_valid sampled at edge k with FIFO and register empty -> m_axis_tvalid=1 after edge k+1.
  - AXIS rule: once m_axis_tvalid=1, tdata stays stable and tvalid stays high until the beat is accepted (tvalid and tready both high at an edge).
  - Back-to-back beats: one beat per cycle sustained while tready=1 and data is available.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
  - enable=0 does not flush; buffered samples continue to drain.
- Effective capacity is fifo_depth+1 samples (FIFO plus output register).

Decomposition:
- Shared package ecg_pkg:
  - ECG_INOUT_WIDTH=16
  - ECG_FS_HZ=500
  - ECG_CLK_HZ=100_000_000
  - ECG_CLK_DIV = ECG_CLK_HZ / ECG_FS_HZ
  - offset_to_signed conversion function
- One sub-module, axis_sync_fifo (parameters: width, depth): storage, pointers, full/empty, level.
- The top level holds the tick counter, conversion, overflow logic and output register.

Test Plan:
- Reset then enable=1 with clk_div=10 -> adc_convst pulses at cycles 10, 20, 30 after enable; no pulses while rst=1 or enable=0.
- adc_data 12'h800, 12'hFFF, 12'h000, 12'h801 with tready=1 -> tdata 16'h0000, 16'h7FF0, 16'h8000, 16'h0010 in order; tvalid rises one cycle after each adc_valid.
- tready=0, push 17 samples (fifo_depth=16) -> tvalid=1 with tdata held at sample 0, fifo_level=16, overflow=0. 18th push -> overflow=1, overflow_count=1, fifo_level stays 16. Then tready=1 -> samples 0..16 drain in order, one per cycle.
- Random tready (50%) with adc_valid every cycle for 1000 cycles -> scoreboard shows no reordering, no duplication, tdata stable while stalled, and accepted + dropped = pushed.
- overflow_clr asserted in the same cycle as a full-FIFO drop -> overflow=1, overflow_count=1; overflow_clr alone -> both 0.
- rst asserted with 5 samples buffered and tvalid=1 -> next cycle tvalid=0, fifo_level=0; a subsequent push emerges first with correct data.
